// File: rtl/morse_player.sv
// morse_player: plays one Morse word of up to five symbols on a lamp/buzzer.
// Optional feature: define MORSE_PLAYER_LETTER_GAP_EN to append a letter gap
// of two extra ticks after the last symbol gap before done is pulsed.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   start  one-cycle play request, accepted only while idle
//   code   word: five 2-bit pairs, MSB pair first, {valid, long}
//   tick   one-cycle unit-time enable
//   lamp   registered lamp/buzzer drive
//   busy   registered, high while the word is being played
//   done   registered one-cycle end-of-word pulse
module morse_player #(
  parameter int unsigned DOT_UNITS  = 1,
  parameter int unsigned DASH_UNITS = 3,
  parameter int unsigned GAP_UNITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] code,
  input  logic       tick,
  output logic       lamp,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_SYMBOLS = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ON    = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef MORSE_PLAYER_LETTER_GAP_EN
  localparam logic [2:0] S_LGAP  = 3'd5;
  localparam int unsigned LGAP_UNITS = 2;
`endif

  logic [2:0] state, state_nx;
  logic [9:0] shreg, shreg_nx;
  logic [2:0] sym_cnt, sym_cnt_nx;
  logic [3:0] unit_cnt, unit_cnt_nx;
  logic       lamp_nx, busy_nx, done_nx;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      shreg    <= '0;
      sym_cnt  <= '0;
      unit_cnt <= '0;
      lamp     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      sym_cnt  <= sym_cnt_nx;
      unit_cnt <= unit_cnt_nx;
      lamp     <= lamp_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    sym_cnt_nx  = sym_cnt;
    unit_cnt_nx = unit_cnt;
    lamp_nx     = lamp;
    done_nx     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          shreg_nx   = code;
          sym_cnt_nx = 3'd0;
          state_nx   = S_FETCH;
        end
      end

      // Decode the top pair; tick is deliberately ignored here.
      S_FETCH: begin
        if (shreg[9] && (sym_cnt != 3'(MAX_SYMBOLS))) begin
          unit_cnt_nx = shreg[8] ? 4'(DASH_UNITS) : 4'(DOT_UNITS);
          lamp_nx     = 1'b1;
          state_nx    = S_ON;
        end else begin
`ifdef MORSE_PLAYER_LETTER_GAP_EN
          unit_cnt_nx = 4'(LGAP_UNITS);
          state_nx    = S_LGAP;
`else
          done_nx     = 1'b1;
          state_nx    = S_DONE;
`endif
        end
      end

      S_ON: begin
        if (tick) begin
          if (unit_cnt == 4'd1) begin
            lamp_nx     = 1'b0;
            unit_cnt_nx = 4'(GAP_UNITS);
            state_nx    = S_GAP;
          end else begin
            unit_cnt_nx = unit_cnt - 4'd1;
          end
        end
      end

      // Last gap tick moves to the next pair.
      S_GAP: begin
        if (tick) begin
          if (unit_cnt == 4'd1) begin
            shreg_nx    = {shreg[7:0], 2'b00};
            sym_cnt_nx  = sym_cnt + 3'd1;
            state_nx    = S_FETCH;
          end else begin
            unit_cnt_nx = unit_cnt - 4'd1;
          end
        end
      end

`ifdef MORSE_PLAYER_LETTER_GAP_EN
      // Extra silence that stretches the final symbol gap to a letter gap.
      S_LGAP: begin
        if (tick) begin
          if (unit_cnt == 4'd1) begin
            done_nx  = 1'b1;
            state_nx = S_DONE;
          end else begin
            unit_cnt_nx = unit_cnt - 4'd1;
          end
        end
      end
`endif

      // One-cycle done; start is not sampled here.
      S_DONE: begin
        lamp_nx  = 1'b0;
        state_nx = S_IDLE;
      end

      default: begin
        lamp_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase

    busy_nx = (state_nx == S_FETCH) || (state_nx == S_ON) || (state_nx == S_GAP);
`ifdef MORSE_PLAYER_LETTER_GAP_EN
    if (state_nx == S_LGAP) busy_nx = 1'b1;
`endif
  end

endmodule

// File: tb/tb_morse_player.sv
// tb_morse_player: randomized self-checking bench for morse_player.
// A word-level reference model turns each word plus the tick schedule into
// the expected per-edge {lamp, busy, done} trace, compared every cycle.
module tb_morse_player;

  localparam int unsigned DOT  = 1;
  localparam int unsigned DASH = 3;
  localparam int unsigned GAPU = 1;
  localparam int          HOR  = 12000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] code;
  logic       tick;
  logic       lamp, busy, done;

  morse_player #(
    .DOT_UNITS (DOT),
    .DASH_UNITS(DASH),
    .GAP_UNITS (GAPU)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .code (code),
    .tick (tick),
    .lamp (lamp),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  bit         tk [HOR];
  bit         st [HOR];
  logic [9:0] cdv[HOR];
  logic [2:0] ex [HOR];   // expected {lamp, busy, done} just after edge e

  int n_cmp = 0;
  int n_err = 0;
  int last_edge;
  int mark_edge;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Edge of the n-th tick strictly after edge 'after'.
  function automatic int nth_tick(input int after, input int n);
    int cnt = 0;
    for (int e = after + 1; e < HOR - 4; e++) begin
      if (tk[e]) cnt++;
      if (cnt == n) return e;
    end
    return HOR - 4;
  endfunction

  function automatic logic [9:0] rand_code();
    logic [9:0] c;
    int nv;
    nv = int'($urandom_range(0, 5));
    c  = 10'($urandom);
    for (int p = 0; p < 5; p++) begin
      if (p < nv)       c[9-2*p] = 1'b1;
      else if (p == nv) c[9-2*p] = 1'b0;
    end
    return c;
  endfunction

  task automatic gen_ticks();
    int mode, ph;
    for (int b = 0; b < HOR; b += 64) begin
      mode = (b < 384) ? 0 : int'($urandom_range(0, 3));
      ph   = int'($urandom_range(0, 3));
      for (int e = b; e < b + 64 && e < HOR; e++) begin
        case (mode)
          0:       tk[e] = (e % 4 == 0);
          1:       tk[e] = ($urandom_range(0, 2) == 0);
          2:       tk[e] = 1'b1;
          default: tk[e] = (e % 4 == ph);
        endcase
      end
    end
  endtask

  // Builds stimulus and expected trace for up to nw words.
  task automatic build(input int nw, input bit directed);
    logic [9:0] c, q;
    int t, s, f, a, g, d, len;
    for (int e = 0; e < HOR; e++) begin
      st[e]  = 1'b0;
      ex[e]  = 3'b000;
      cdv[e] = 10'($urandom);
    end
    t = 0;
    last_edge = 4;
    for (int w = 0; w < nw; w++) begin
      if (t > HOR - 600) break;
      s = t + ((w == 0) ? 0 : int'($urandom_range(0, 3)));
      if (directed && w == 0)      c = 10'b1011000000;
      else if (directed && w == 1) c = 10'b1010101010;
      else if (directed && w == 2) c = 10'b0011111111;
      else if (directed && w == 3) c = 10'b1011000000;
      else                         c = rand_code();
      st[s]  = 1'b1;
      cdv[s] = c;
      q = c;
      f = s + 1;
      for (int k = 0; k < 5; k++) begin
        if (!q[9]) break;
        len = q[8] ? int'(DASH) : int'(DOT);
        a = nth_tick(f, len);
        for (int e = f; e < a; e++) ex[e][2] = 1'b1;
        if (directed && w == 0 && k == 1) mark_edge = f + 1;
        g = nth_tick(a, int'(GAPU));
        f = g + 1;
        q = {q[7:0], 2'b00};
      end
`ifdef MORSE_PLAYER_LETTER_GAP_EN
      d = nth_tick(f, 2);
`else
      d = f;
`endif
      for (int e = s; e < d; e++) ex[e][1] = 1'b1;
      ex[d][0] = 1'b1;
      if (directed && w == 3) begin
        st[s + 2] = 1'b1;
        st[s + 5] = 1'b1;
        st[d + 1] = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        st[int'($urandom_range(s + 1, d + 1))] = 1'b1;
      end
      t = d + 2;
      last_edge = d + 3;
    end
  endtask

  task automatic drive(input int upto);
    for (int e = 0; e <= upto; e++) begin
      @(negedge clk);
      tick  = tk[e];
      start = st[e];
      code  = cdv[e];
      @(posedge clk);
      #1;
      check($sformatf("e%0d_lamp_busy_done", e), {lamp, busy, done}, ex[e]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    code  = '0;
    mark_edge = 0;
    #12;
    check("reset_state", {lamp, busy, done}, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    gen_ticks();
    build(200, 1'b1);
    drive(last_edge);

    // Abort "A" during its dash.
    @(negedge clk);
    start = 1'b0;
    tick  = 1'b0;
    build(1, 1'b1);
    drive(mark_edge);
    check("dash_lamp_on", {31'd0, lamp}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", {lamp, busy, done}, 3'b000);
    start = 1'b0;
    tick  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_quiet%0d", i), {lamp, busy, done}, 3'b000);
    end

    gen_ticks();
    build(60, 1'b1);
    drive(last_edge);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
